// File: rtl/sixbitmulseq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sixbitmulseq_pkg : shared widths, limits and FSM states for the multiplier |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sixbitmulseq_pkg;

    localparam int DATA_W = 6;
    localparam int ACC_W  = 12;
    localparam int CNT_W  = 3;

    localparam logic [ACC_W-1:0] MAX_POS     = ACC_W'(31);
    localparam logic [ACC_W-1:0] MAX_NEG_MAG = ACC_W'(32);
    localparam logic [CNT_W-1:0] LAST_ITER   = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sixbitneg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sixbitneg : combinational conditional two's-complement negate              |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sixbitneg
    import sixbitmulseq_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic              neg_en,
    output logic [DATA_W-1:0] data_out
);

    // Negating -32 yields 6'b100000, which reads correctly as unsigned magnitude 32.
    assign data_out = neg_en ? (~data_in + DATA_W'(1)) : data_in;

endmodule
`default_nettype wire

// File: rtl/sixbitmulseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sixbitmulseq : sequential 6-bit signed shift-add multiplier, one bit/clock |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sixbitmulseq
    import sixbitmulseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic [DATA_W-1:0] product,
    output logic              err,
    output logic              busy,
    output logic              done
);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_capture;
    logic               w_iterate;
    logic               w_finish;

    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mag_a;
    logic [DATA_W-1:0]  r_mag_b;
    logic               r_sign;
    logic [ACC_W-1:0]   r_acc;

    logic [DATA_W-1:0]  w_mag_a;
    logic [DATA_W-1:0]  w_mag_b;
    logic [ACC_W-1:0]   w_addend;
    logic [ACC_W-1:0]   w_acc_next;
    logic [DATA_W-1:0]  w_prod_pos;
    logic [DATA_W-1:0]  w_prod_neg;
    logic [DATA_W-1:0]  w_prod;
    logic               w_err;

    sixbitneg u_neg_a (
        .data_in  (multiplicand),
        .neg_en   (multiplicand[DATA_W-1]),
        .data_out (w_mag_a)
    );

    sixbitneg u_neg_b (
        .data_in  (multiplier),
        .neg_en   (multiplier[DATA_W-1]),
        .data_out (w_mag_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_iterate    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_iterate = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_finish     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The last partial product is added on the same edge that loads the result,
    // so the result is formed from the post-add accumulator value.
    assign w_addend   = r_mag_b[r_cnt] ? (ACC_W'(r_mag_a) << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_prod_pos = w_acc_next[DATA_W-1:0];
    assign w_prod_neg = ~w_acc_next[DATA_W-1:0] + DATA_W'(1);
    assign w_prod     = r_sign ? w_prod_neg : w_prod_pos;
    assign w_err      = r_sign ? (w_acc_next > MAX_NEG_MAG) : (w_acc_next > MAX_POS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_sign  <= 1'b0;
            r_acc   <= '0;
            product <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (w_next_state == RUN);
            done <= (w_next_state == DONE);
            if (w_capture) begin
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_sign  <= multiplicand[DATA_W-1] ^ multiplier[DATA_W-1];
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (w_iterate) begin
                r_acc <= w_acc_next;
                r_cnt <= w_finish ? '0 : r_cnt + CNT_W'(1);
                if (w_finish) begin
                    product <= w_prod;
                    err     <= w_err;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sixbitmulseq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sixbitmulseq : scoreboard bench for the sequential 6-bit multiplier     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sixbitmulseq;

    typedef struct {
        logic [5:0] prod;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] multiplicand = '0;
    logic [5:0] multiplier = '0;
    logic [5:0] product;
    logic       err;
    logic       busy;
    logic       done;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    sixbitmulseq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .err          (err),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic signed [5:0] a, input logic signed [5:0] b);
        exp_t e;
        int   p;
        p      = int'(a) * int'(b);
        e.prod = p[5:0];
        e.err  = (p < -32) || (p > 31);
        return e;
    endfunction

    // Applies operands with a one-cycle start pulse; returns at the negedge after the accepting edge.
    task automatic drive_op(input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit found, output bit busy_ok);
        found   = 1'b0;
        busy_ok = 1'b1;
        cycles  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                cycles  = k;
                found   = 1'b1;
                busy_ok = busy_ok && !busy;
                return;
            end
            busy_ok = busy_ok && busy;
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({product, err, busy, done} !== 9'd0)
            $display("FAIL reset_outputs: got prod=%b err=%b busy=%b done=%b, want all 0", product, err, busy, done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_directed;
        logic [5:0] va [7] = '{6'd3, 6'h3C, 6'd4, 6'h20, 6'h20, 6'd0,  6'h3F};
        logic [5:0] vb [7] = '{6'd5, 6'd8,  6'd8, 6'h3F, 6'd1,  6'h20, 6'h3F};
        int   cyc;
        bit   found, bok;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            drive_op(va[i], vb[i]);
            wait_done(cyc, found, bok);
            e = sb.pop_front();
            n_checks++;
            if (!found || cyc != 6)
                $display("FAIL dir_latency[%0d]: got %0d cycles (found=%0b), want 6", i, cyc, found);
            else n_pass++;
            n_checks++;
            if (!bok) $display("FAIL dir_busy[%0d]: got busy not high only through RUN, want high in RUN", i);
            else n_pass++;
            n_checks++;
            if (product !== e.prod)
                $display("FAIL dir_product[%0d]: got %b, want %b", i, product, e.prod);
            else n_pass++;
            n_checks++;
            if (err !== e.err) $display("FAIL dir_err[%0d]: got %b, want %b", i, err, e.err);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || product !== e.prod)
                $display("FAIL dir_hold[%0d]: got done=%b prod=%b, want done=0 prod=%b", i, done, product, e.prod);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int   k;
        exp_t e;
        @(negedge clk);
        multiplicand = 6'd7;
        multiplier   = 6'd7;
        start        = 1'b1;
        sb.push_back(model(6'd7, 6'd7));
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        n_checks++;
        if (!done || k != 7 || product !== 6'b110001 || err !== 1'b1 || product !== e.prod)
            $display("FAIL b2b_first: got done=%b at %0d prod=%b err=%b, want done at 7 prod=110001 err=1",
                     done, k, product, err);
        else n_pass++;
        // start is still high in the DONE cycle, so 7x7 is captured again.
        sb.push_back(model(6'd7, 6'd7));
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
            multiplicand = 6'($urandom);
            multiplier   = 6'($urandom);
            start        = (i < 6) ? i[0] : 1'b0;
        end
        e = sb.pop_front();
        n_checks++;
        if (k != 7) $display("FAIL b2b_spacing: got %0d clocks, want 7", k);
        else n_pass++;
        n_checks++;
        if (product !== e.prod || err !== e.err)
            $display("FAIL b2b_second: got prod=%b err=%b, want prod=%b err=%b", product, err, e.prod, e.err);
        else n_pass++;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int   cyc;
        bit   found, bok, saw_done;
        exp_t e;
        drive_op(6'd5, 6'd5);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        n_checks++;
        if ({product, err, busy, done} !== 9'd0)
            $display("FAIL abort_clear: got prod=%b err=%b busy=%b done=%b, want all 0", product, err, busy, done);
        else n_pass++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done || done;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            saw_done = saw_done || done;
        end
        n_checks++;
        if (saw_done) $display("FAIL abort_no_done: got done=1 after abort, want 0");
        else n_pass++;
        drive_op(6'd2, 6'd3);
        wait_done(cyc, found, bok);
        e = sb.pop_front();
        n_checks++;
        if (!found || product !== 6'd6 || err !== 1'b0 || e.prod !== 6'd6)
            $display("FAIL abort_recover: got found=%0b prod=%b err=%b, want prod=000110 err=0", found, product, err);
        else n_pass++;
    endtask

    task automatic test_sweep;
        logic [11:0] idx;
        int          seed;
        int          cyc;
        bit          found, bok;
        exp_t        e;
        seed = int'($urandom_range(0, 4095));
        for (int i = 0; i < 4096; i++) begin
            idx = 12'((i * 1237 + seed) % 4096);
            drive_op(idx[11:6], idx[5:0]);
            wait_done(cyc, found, bok);
            e = sb.pop_front();
            n_checks++;
            if (!found || cyc != 6) begin
                $display("FAIL sweep_done a=%0d b=%0d: got %0d cycles, want 6",
                         $signed(idx[11:6]), $signed(idx[5:0]), cyc);
                if (!found) break;
            end else n_pass++;
            n_checks++;
            if (product !== e.prod || err !== e.err)
                $display("FAIL sweep a=%0d b=%0d: got prod=%b err=%b, want prod=%b err=%b",
                         $signed(idx[11:6]), $signed(idx[5:0]), product, err, e.prod, e.err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sixbitmulseq.md
# sixbitmulseq

Sequential 6-bit two's-complement multiplier for the calculator datapath, the inverse operation of the existing combinational 6-bit divider. It accepts two signed operands on a start pulse and runs a shift-add loop on operand magnitudes, one partial product per clock. It returns a signed 6-bit product with an overflow/error flag and a one-cycle done strobe. It sits beside the divider in the ALU and is sequenced by the calculator control FSM.

## Interface
- Parameters: none; width fixed at 6 bits to match the calculator datapath.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when not busy
- multiplicand  in  6  signed two's-complement operand A
- multiplier  in  6  signed two's-complement operand B
- product  out  6  signed result, low 6 bits of true A*B
- err  out  1  true product outside [-32, 31]
- busy  out  1  operation in progress
- done  out  1  one-cycle strobe, product/err valid

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → capture operands, go to RUN.
  - RUN: 6 iterations, tracked by a 3-bit counter 0..5. Counter=5 → DONE.
  - DONE: start=1 → capture operands, go to RUN; otherwise go to IDLE.
- Capture step:
  - magA = |A| and magB = |B|, each as 6-bit unsigned. |-32| = 32 (6'b100000), which is valid unsigned.
  - sign = A[5] ^ B[5].
  - 12-bit accumulator cleared.
- Each RUN cycle:
  - If magB[i] = 1, add magA << i into the accumulator, with i = counter.
  - The accumulator never exceeds 1024, so 12 bits cannot overflow.
- Result, registered on the RUN→DONE edge:
  - product = sign ? low6(~acc + 1) : low6(acc).
  - err = sign ? (acc > 32) : (acc > 31).
- If either operand is zero: acc = 0, product = 0, err = 0, and sign is irrelevant.
- product and err hold their value until the next RUN→DONE edge. They do not clear on IDLE.
- start while in RUN is ignored. The operands in flight are unaffected, and input changes after capture are ignored.

## Timing
- Reset (async assert): state = IDLE, counter = 0, acc = 0, product = 0, err = 0, busy = 0, done = 0. Synchronous deassert is provided externally.
- Start accepted at edge E0 → busy = 1 after E0.
- Iterations occur at edges E1..E6.
- E6 also loads product/err and enters DONE.
- During the cycle after E6: done = 1 and busy = 0.
- Latency: 6 clocks from the accepting edge to done.
- Throughput: start held high gives one result every 7 clocks. The DONE cycle accepts a new start.
- busy is a registered function of state (RUN only). done is a registered function of state (DONE only). Both are glitch-free.
- Reset asserted mid-RUN aborts the operation. No done is produced, and the previous product is cleared to 0.

## Structure
- Shared calculator package holds:
  - DATA_W = 6, ACC_W = 12, CNT_W = 3.
  - State enumeration IDLE/RUN/DONE.
  - Constants MAX_POS = 31 and MAX_NEG_MAG = 32.
- One sub-module, sixbitneg, is natural: a combinational 6-bit conditional two's-complement negate (in, neg_en → out). It is instantiated twice for the operand magnitudes; the result negation is done inline on the low 6 bits.
- The top level contains the FSM, counter, operand/accumulator registers and result registers.

## Test plan
- 3 × 5, start pulsed one cycle: done exactly 6 clocks after the accepting edge. Expect product = 15 (6'b001111), err = 0, and busy high only through the RUN cycles.
- -4 × 8: product = 6'b100000 (-32), err = 0. 4 × 8: product = 6'b100000, err = 1.
- -32 × -1: err = 1 with product = 6'b100000. -32 × 1: product = -32 with err = 0. 0 × -32: product = 0, err = 0. -1 × -1: product = 1, err = 0.
- Hold start high with operands 7 × 7:
  - First done at 6 clocks, err = 1, product = low6(49) = 6'b110001.
  - New operation accepted in the DONE cycle; next done 7 clocks later.
  - start pulses and operand changes during RUN do not alter the result.
- Assert rst_n low at iteration 3 of 5 × 5, asynchronously between edges. All outputs go to 0 immediately, no done appears, and a subsequent 2 × 3 yields 6 with err = 0.
- Randomised sweep of all 4096 operand pairs against a reference model: product equals low6(A*B), and err equals (A*B < -32 || A*B > 31).
